// File: rtl/syn_md_pkg.sv
// Shared constants for the sync-mode controller: state codes and parameter defaults.
package syn_md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ABORT  = 2'd3
  } syn_md_state_e;

  localparam logic [2:0] EXPECT_DEF     = 3'b011;
  localparam int         DEB_CYCLES_DEF = 16;
  localparam int         ARM_CYCLES_DEF = 4;

endpackage

// File: rtl/sw_debounce.sv
// One switch input: two-flop synchronizer followed by an optional stability filter.
// The filter exists only when SYN_MD_DEBOUNCE_EN is defined; otherwise the synchronized bit passes straight through.
module sw_debounce
  import syn_md_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic filt_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
    end
  end

`ifdef SYN_MD_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  // Count consecutive cycles of disagreement; any agreement restarts from zero.
  always_comb begin
    cnt_d  = 8'd0;
    filt_d = filt_q;
    if (sync_q != filt_q) begin
      if (cnt_q >= DEB_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  logic unused_deb;
  assign unused_deb = ^8'(DEB_CYCLES);
  assign filt_o     = sync_q;
`endif

endmodule

// File: rtl/syn_md_ctrl.sv
// Sync-mode controller: filtered switch status must match EXPECT for ARM_CYCLES before sync mode is enabled.
// Debounce filters are built only when SYN_MD_DEBOUNCE_EN is defined.
module syn_md_ctrl
  import syn_md_pkg::*;
#(
  parameter int              N_SW       = 3,
  parameter logic [N_SW-1:0] EXPECT     = N_SW'(EXPECT_DEF),
  parameter int              DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int              ARM_CYCLES = ARM_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            soft_d,
  input  logic [N_SW-1:0] sw_in,
  output logic            syn_md,
  output logic [1:0]      syn_md_state,
  output logic            fault
);

  localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES);

  logic [N_SW-1:0] filt;
  logic            match;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .sw_i  (sw_in[g]),
      .filt_o(filt[g])
    );
  end

  assign match = (filt == EXPECT);

  syn_md_state_e state_q;
  logic [7:0]    arm_cnt_q;
  logic          syn_md_q;
  logic          fault_q;

  // syn_md and fault are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arm_cnt_q <= 8'd0;
      syn_md_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      syn_md_q <= 1'b0;
      fault_q  <= 1'b0;
      if (soft_d) begin
        state_q   <= ST_ABORT;
        arm_cnt_q <= 8'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (match) begin
              state_q   <= ST_ARM;
              arm_cnt_q <= 8'd1;
            end
          end
          ST_ARM: begin
            if (!match) begin
              state_q   <= ST_IDLE;
              arm_cnt_q <= 8'd0;
            end else if (arm_cnt_q >= ARM_LAST) begin
              state_q   <= ST_ACTIVE;
              arm_cnt_q <= 8'd0;
              syn_md_q  <= 1'b1;
            end else begin
              arm_cnt_q <= arm_cnt_q + 8'd1;
            end
          end
          ST_ACTIVE: begin
            if (!match) begin
              state_q <= ST_IDLE;
              fault_q <= 1'b1;
            end else begin
              syn_md_q <= 1'b1;
            end
          end
          ST_ABORT: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign syn_md       = syn_md_q;
  assign syn_md_state = state_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_syn_md_ctrl.sv
// Directed bench for syn_md_ctrl: arming latency, glitch rejection, mismatch fault, soft disable, reset and aborted arming.
module tb_syn_md_ctrl;

  localparam int N_SW = 3;
  localparam int DEB  = 16;
  localparam int ARMC = 4;
`ifdef SYN_MD_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 2 + D + ARMC + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            soft_d;
  logic [N_SW-1:0] sw_in;
  logic            syn_md;
  logic [1:0]      syn_md_state;
  logic            fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  syn_md_ctrl #(
    .N_SW      (N_SW),
    .EXPECT    (3'b011),
    .DEB_CYCLES(DEB),
    .ARM_CYCLES(ARMC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_d      (soft_d),
    .sw_in       (sw_in),
    .syn_md      (syn_md),
    .syn_md_state(syn_md_state),
    .fault       (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    soft_d = 1'b0;
    sw_in  = 3'b000;
    repeat (3) step();
    checks++;
    if (syn_md_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", syn_md_state); end
    checks++;
    if (syn_md !== 1'b0) begin errors++; $display("FAIL reset_syn_md got %b exp 0", syn_md); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    rst = 1'b0;
    step();
    checks++;
    if (syn_md_state !== 2'd0) begin errors++; $display("FAIL post_reset_idle got %0d exp 0", syn_md_state); end
  endtask

  // Apply the matching pattern now and expect syn_md exactly LAT edges later.
  task automatic go_active(input string name);
    logic exp_syn;
    sw_in = 3'b011;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      exp_syn = (i >= LAT);
      checks++;
      if (syn_md !== exp_syn) begin
        errors++; $display("FAIL %s syn_md edge %0d got %b exp %b", name, i, syn_md, exp_syn);
      end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL %s fault edge %0d got %b exp 0", name, i, fault); end
      if (i == LAT - 1) begin
        checks++;
        if (syn_md_state !== 2'd1) begin errors++; $display("FAIL %s arm_state got %0d exp 1", name, syn_md_state); end
      end
      if (i == LAT) begin
        checks++;
        if (syn_md_state !== 2'd2) begin errors++; $display("FAIL %s active_state got %0d exp 2", name, syn_md_state); end
      end
    end
  endtask

`ifdef SYN_MD_DEBOUNCE_EN
  task automatic test_glitch();
    sw_in = 3'b111;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) sw_in = 3'b011;
      step();
      checks++;
      if (syn_md !== 1'b1) begin errors++; $display("FAIL glitch syn_md edge %0d got %b exp 1", i, syn_md); end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL glitch fault edge %0d got %b exp 0", i, fault); end
    end
    checks++;
    if (syn_md_state !== 2'd2) begin errors++; $display("FAIL glitch state got %0d exp 2", syn_md_state); end
  endtask
`endif

  task automatic test_mismatch();
    logic exp_syn, exp_fault;
    sw_in = 3'b111;
    for (int i = 1; i <= D + 6; i++) begin
      step();
      exp_syn   = (i < D + 3);
      exp_fault = (i == D + 3);
      checks++;
      if (syn_md !== exp_syn) begin errors++; $display("FAIL mismatch syn_md edge %0d got %b exp %b", i, syn_md, exp_syn); end
      checks++;
      if (fault !== exp_fault) begin errors++; $display("FAIL mismatch fault edge %0d got %b exp %b", i, fault, exp_fault); end
      if (i == D + 3) begin
        checks++;
        if (syn_md_state !== 2'd0) begin errors++; $display("FAIL mismatch state got %0d exp 0", syn_md_state); end
      end
    end
    go_active("rearm");
  endtask

  task automatic test_soft_disable();
    logic [1:0] exp_st;
    soft_d = 1'b1;
    for (int i = 1; i <= ARMC + 7; i++) begin
      if (i == 4) soft_d = 1'b0;
      step();
      if (i <= 3)             exp_st = 2'd3;
      else if (i == 4)        exp_st = 2'd0;
      else if (i <= 4 + ARMC) exp_st = 2'd1;
      else                    exp_st = 2'd2;
      checks++;
      if (syn_md_state !== exp_st) begin errors++; $display("FAIL soft state edge %0d got %0d exp %0d", i, syn_md_state, exp_st); end
      checks++;
      if (syn_md !== (exp_st == 2'd2)) begin errors++; $display("FAIL soft syn_md edge %0d got %b exp %b", i, syn_md, exp_st == 2'd2); end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL soft fault edge %0d got %b exp 0", i, fault); end
    end
  endtask

  task automatic test_reset_active();
    checks++;
    if (syn_md !== 1'b1) begin errors++; $display("FAIL rst_pre syn_md got %b exp 1", syn_md); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (syn_md !== 1'b0) begin errors++; $display("FAIL rst_async syn_md got %b exp 0", syn_md); end
    checks++;
    if (syn_md_state !== 2'd0) begin errors++; $display("FAIL rst_async state got %0d exp 0", syn_md_state); end
    sw_in = 3'b000;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if (syn_md_state !== 2'd0) begin errors++; $display("FAIL rst_release state got %0d exp 0", syn_md_state); end
  endtask

  // Bits 0/1 match first, bit 2 breaks the match three filtered cycles later: ARM reaches count 3 then drops.
  task automatic test_arm_abort();
    sw_in = 3'b011;
    for (int i = 1; i <= D + 12; i++) begin
      if (i == 4) sw_in = 3'b111;
      step();
      checks++;
      if (syn_md !== 1'b0) begin errors++; $display("FAIL arm_abort syn_md edge %0d got %b exp 0", i, syn_md); end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL arm_abort fault edge %0d got %b exp 0", i, fault); end
      if (i == D + 3 || i == D + 5) begin
        checks++;
        if (syn_md_state !== 2'd1) begin errors++; $display("FAIL arm_abort arm edge %0d got %0d exp 1", i, syn_md_state); end
      end
      if (i == D + 6) begin
        checks++;
        if (syn_md_state !== 2'd0) begin errors++; $display("FAIL arm_abort idle got %0d exp 0", syn_md_state); end
      end
    end
  endtask

  initial begin
    test_reset();
    go_active("first_arm");
`ifdef SYN_MD_DEBOUNCE_EN
    test_glitch();
`endif
    test_mismatch();
    test_soft_disable();
    test_reset_active();
    test_arm_abort();
    go_active("after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_md_ctrl.md
SYN_MD_CTRL -- requirements
Module: syn_md_ctrl

Interface
REQ-001 Parameter N_SW, default 3: number of switch-status inputs combined.
REQ-002 Parameter EXPECT, default 3'b011: required level per switch; bit i applies to sw_in[i].
REQ-003 Parameter DEB_CYCLES, default 16, range 1..255: consecutive stable cycles before a filtered switch changes.
REQ-004 Parameter ARM_CYCLES, default 4, range 1..255: consecutive matched cycles before sync mode activates.
REQ-005 clk  in  1  system clock; the block's only clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 soft_d  in  1  software disable, synchronous to clk; 1 forces sync mode off.
REQ-008 sw_in  in  N_SW  asynchronous switch-status inputs (rt_sw, sw1, sw2 order at default).
REQ-009 syn_md  out  1  registered sync-mode enable.
REQ-010 syn_md_state  out  2  current FSM state code.
REQ-011 fault  out  1  one-cycle pulse when ACTIVE is lost through switch mismatch.

Function
REQ-012 Each sw_in bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each synchronized bit SHALL feed a debounce filter: the filtered value takes the synchronized value only after it has differed from the filtered value for DEB_CYCLES consecutive cycles; any reversion restarts the count at 0.
REQ-014 match SHALL be 1 iff every filtered bit equals its EXPECT bit.
REQ-015 FSM states SHALL be IDLE=0, ARM=1, ACTIVE=2, ABORT=3, driven on syn_md_state.
REQ-016 Any state with soft_d=1 SHALL go to ABORT next cycle; soft_d has priority over all other transitions.
REQ-017 IDLE -> ARM when match=1; ARM counter loads 1.
REQ-018 ARM: match=1 increments counter; counter reaching ARM_CYCLES -> ACTIVE; match=0 -> IDLE, counter cleared.
REQ-019 ACTIVE: match=0 -> IDLE and fault=1 for exactly that transition cycle's following cycle (one pulse).
REQ-020 ABORT -> IDLE on the first cycle soft_d=0; never direct to ARM or ACTIVE.
REQ-021 syn_md SHALL be 1 iff registered state is ACTIVE; no combinational path from any input to syn_md.
REQ-022 Latency, soft_d 1 to syn_md 0: one clock edge.
REQ-023 Counters SHALL saturate; no wrap-around at any parameter value.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, syn_md=0, fault=0, counters 0, synchronizer and filtered bits 0.
REQ-025 Reset asserted mid-ARM or mid-ACTIVE SHALL drop syn_md within the same cycle of rst assertion; release resumes from IDLE with full re-debounce.

Configuration
REQ-026 Macro SYN_MD_DEBOUNCE_EN: defined -> REQ-013 filters instantiated; undefined -> filtered value equals synchronized value, DEB_CYCLES ignored, no debounce counters synthesized.

Structure
REQ-027 Package syn_md_pkg SHALL hold the state encoding constants and the EXPECT/DEB_CYCLES/ARM_CYCLES defaults.
REQ-028 Sub-module sw_debounce (one synchronizer plus filter per bit) SHALL be instantiated N_SW times via generate.

Verification
REQ-029 Reset release, sw_in=3'b011 held, soft_d=0, debounce on -> syn_md rises 2+16+4+1 cycles after first stable input (within one cycle), fault stays 0.
REQ-030 sw_in bit 2 glitch high for 10 cycles while ACTIVE (DEB_CYCLES=16) -> syn_md stays 1, fault 0.
REQ-031 sw_in bit 2 held high 20 cycles while ACTIVE -> syn_md falls after sync+16 cycles, fault single 1-cycle pulse, state IDLE.
REQ-032 soft_d pulsed 1 for 3 cycles while ACTIVE -> syn_md 0 next edge, state ABORT, IDLE after soft_d low, ACTIVE again after ARM_CYCLES with no fault.
REQ-033 Match dropped at ARM count 3 of 4 -> state IDLE, syn_md never asserts; rst asserted while ACTIVE -> syn_md 0 immediately.
REQ-034 Debounce macro undefined, same stimulus as REQ-029 -> syn_md rises 2+4+1 cycles after input stable.
